// File: rtl/radius_feeder_pkg.sv
// Shared types and default sizing for the radius-stream feeder.
package radius_feeder_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} feeder_state_t;

  localparam int FEEDER_DEPTH    = 16;
  localparam int FEEDER_GROUP    = 4;
  localparam int FEEDER_RADIUS_W = 16;
  localparam int FEEDER_AREA_W   = 26;
  localparam int FEEDER_TMO_CYC  = 64;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int FEEDER_PTR_W = idx_w(FEEDER_DEPTH);
  localparam int FEEDER_RES_W = idx_w(FEEDER_DEPTH / FEEDER_GROUP);

endpackage

// File: rtl/radius_frame_buf.sv
// Frame sample store: one write port, one registered read port that outputs 0 when not reading.
module radius_frame_buf
  import radius_feeder_pkg::*;
#(
  parameter int DEPTH = FEEDER_DEPTH,
  parameter int W     = FEEDER_RADIUS_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem [DEPTH];

  // Contents survive reset so a frame can be replayed after an abort.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
    else         rdata <= '0;
  end

endmodule

// File: rtl/radius_stream_feeder.sv
// Streams a DEPTH-sample radius frame to the converter and collects one area per GROUP samples.
// Optional drain watchdog: define RADIUS_FEEDER_TIMEOUT_EN.
module radius_stream_feeder
  import radius_feeder_pkg::*;
#(
  parameter int DEPTH    = FEEDER_DEPTH,
  parameter int GROUP    = FEEDER_GROUP,
  parameter int RADIUS_W = FEEDER_RADIUS_W,
  parameter int AREA_W   = FEEDER_AREA_W,
  parameter int TMO_CYC  = FEEDER_TMO_CYC
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load_we,
  input  logic [$clog2(DEPTH)-1:0]       load_addr,
  input  logic [RADIUS_W-1:0]            load_data,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           conv_en,
  output logic [RADIUS_W-1:0]            conv_radius,
  input  logic [AREA_W-1:0]              conv_area,
  input  logic                           conv_rdy,
  output logic                           res_valid,
  output logic [AREA_W-1:0]              res_data,
  output logic [$clog2(DEPTH/GROUP)-1:0] res_idx,
  output logic                           err_tmo,
  output feeder_state_t                  dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int RES_W = $clog2(DEPTH / GROUP);
  localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(DEPTH - 1);
  localparam logic [RES_W-1:0] LAST_RES  = RES_W'(DEPTH / GROUP - 1);

  if ((DEPTH % GROUP) != 0 || DEPTH < GROUP || TMO_CYC < 1) begin : g_cfg_check
    $error("radius_stream_feeder: illegal DEPTH/GROUP/TMO_CYC combination");
  end

  // Converter handshake: conv_en qualifies conv_radius for exactly one cycle per sample;
  // there is no back-pressure. conv_rdy is a one-cycle pulse qualifying conv_area and
  // is only honoured while a frame is in flight (STREAM or DRAIN).

  feeder_state_t    state;
  logic [PTR_W-1:0] rd_ptr;
  logic [RES_W-1:0] res_cnt;
  logic             idle_like;
  logic             accept_start;
  logic             rd_en;
  logic             wr_en;
  logic             tmo_hit;

  assign idle_like    = (state == IDLE) || (state == DONE);
  assign accept_start = idle_like && start;
  assign wr_en        = load_we && idle_like;
  assign rd_en        = accept_start || (state == STREAM);
  assign dbg_state    = state;

  radius_frame_buf #(
    .DEPTH (DEPTH),
    .W     (RADIUS_W)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (load_addr),
    .wdata (load_data),
    .re    (rd_en),
    .raddr (rd_ptr),
    .rdata (conv_radius)
  );

`ifdef RADIUS_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == DRAIN) && !conv_rdy && (tmo_cnt == TW'(TMO_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt <= '0;
      err_tmo <= 1'b0;
    end else begin
      if (accept_start) err_tmo <= 1'b0;
      else if (tmo_hit) err_tmo <= 1'b1;
      if (state != DRAIN || conv_rdy) tmo_cnt <= '0;
      else                            tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      res_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      conv_en   <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      done      <= 1'b0;
      res_valid <= 1'b0;

      if ((state == STREAM || state == DRAIN) && conv_rdy) begin
        res_data  <= conv_area;
        res_idx   <= res_cnt;
        res_valid <= 1'b1;
        res_cnt   <= res_cnt + 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          state   <= IDLE;
          busy    <= 1'b0;
          conv_en <= 1'b0;
          if (start) begin
            state   <= STREAM;
            busy    <= 1'b1;
            conv_en <= 1'b1;
            rd_ptr  <= rd_ptr + 1'b1;
            res_cnt <= '0;
          end
        end
        STREAM: begin
          // rd_ptr is the address being fetched now; fetching the last one ends STREAM
          // while that sample is still on the wire, and rd_ptr wraps back to 0.
          conv_en <= 1'b1;
          rd_ptr  <= rd_ptr + 1'b1;
          if (rd_ptr == LAST_ADDR) state <= DRAIN;
        end
        DRAIN: begin
          conv_en <= 1'b0;
          if ((conv_rdy && res_cnt == LAST_RES) || tmo_hit) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
